pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipelined RISC-V core (IF, ID, EX, MEM, WB).
- Detects load-use hazards and inserts one bubble.
- Flushes wrong-path instructions when a branch resolves taken in MEM.
- Generates EX-stage forwarding selects.
- Provides a debug halt/single-step FSM.
- Keeps saturating stall and flush counters.

It drives the enable and flush inputs of `pc`, `IF_ID`, `ID_EX` and `EX_MEM`, and the select inputs of the two ALU-operand forwarding muxes.

---
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, branch flush, forwarding, debug halt/step and event counters
module pipeline_hazard_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         rs1_IF_ID,
  input  logic [4:0]         rs2_IF_ID,
  input  logic [4:0]         rs1_ID_EX,
  input  logic [4:0]         rs2_ID_EX,
  input  logic [4:0]         rd_ID_EX,
  input  logic               memread_ID_EX,
  input  logic [4:0]         rd_EX_MEM,
  input  logic               regwrite_EX_MEM,
  input  logic [4:0]         rd_MEM_WB,
  input  logic               regwrite_MEM_WB,
  input  logic               branch_taken,
  input  logic               halt_req,
  input  logic               step_req,
  output logic               pc_en,
  output logic               if_id_en,
  output logic               pipe_flush,
  output logic               id_ex_bubble,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               halted,
  output logic [COUNT_W-1:0] stall_cnt,
  output logic [COUNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_halted;
  logic               r_step_prev;
  logic [COUNT_W-1:0] r_stall_cnt;
  logic [COUNT_W-1:0] r_flush_cnt;

  logic       w_lu;
  logic       w_stall_evt;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  always_comb begin
    w_lu = memread_ID_EX && (rd_ID_EX != 5'd0) &&
           ((rd_ID_EX == rs1_IF_ID) || (rd_ID_EX == rs2_IF_ID));

    // MEM result is newer than WB data, so it wins when both match
    w_fwd_a = 2'b00;
    if (regwrite_EX_MEM && (rd_EX_MEM != 5'd0) && (rd_EX_MEM == rs1_ID_EX))
      w_fwd_a = 2'b10;
    else if (regwrite_MEM_WB && (rd_MEM_WB != 5'd0) && (rd_MEM_WB == rs1_ID_EX))
      w_fwd_a = 2'b01;

    w_fwd_b = 2'b00;
    if (regwrite_EX_MEM && (rd_EX_MEM != 5'd0) && (rd_EX_MEM == rs2_ID_EX))
      w_fwd_b = 2'b10;
    else if (regwrite_MEM_WB && (rd_MEM_WB != 5'd0) && (rd_MEM_WB == rs2_ID_EX))
      w_fwd_b = 2'b01;

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    pipe_flush   = 1'b0;
    id_ex_bubble = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    w_stall_evt  = 1'b0;

    if (!reset) begin
      fwd_a = w_fwd_a;
      fwd_b = w_fwd_b;
      if (r_state == S_HALTED) begin
        // fetch frozen, younger stages drain behind bubbles
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        pipe_flush   = branch_taken;
      end else if (branch_taken) begin
        pipe_flush   = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (w_lu) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        w_stall_evt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_halted    <= 1'b0;
      r_step_prev <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_step_prev <= step_req;
      case (r_state)
        S_RUN: begin
          // a taken branch holds off the halt so its redirect lands
          if (halt_req && !branch_taken) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end
        end
        S_HALTED: begin
          if (!halt_req) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end else if (step_req && !r_step_prev) begin
            r_state  <= S_STEP;
            r_halted <= 1'b0;
          end
        end
        S_STEP: begin
          r_state  <= S_HALTED;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= S_RUN;
          r_halted <= 1'b0;
        end
      endcase

      if (w_stall_evt && (r_stall_cnt != {COUNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + COUNT_W'(1);
      if (pipe_flush && (r_flush_cnt != {COUNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + COUNT_W'(1);
    end
  end

  assign halted    = r_halted;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks of pipeline_hazard_ctrl against a behavioural model
module tb_pipeline_hazard_ctrl;

  localparam int COUNT_W = 16;
  localparam int MAXC    = (1 << COUNT_W) - 1;
  localparam int M_RUN   = 0;
  localparam int M_HALT  = 1;
  localparam int M_STEP  = 2;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_IF_ID, rs2_IF_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX;
  logic memread_ID_EX;
  logic [4:0] rd_EX_MEM, rd_MEM_WB;
  logic regwrite_EX_MEM, regwrite_MEM_WB;
  logic branch_taken, halt_req, step_req;
  logic pc_en, if_id_en, pipe_flush, id_ex_bubble, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [COUNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;
  bit chk_en = 1'b0;

  int m_mode  = M_RUN;
  bit m_prev  = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_hazard_ctrl #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
    .memread_ID_EX(memread_ID_EX),
    .rd_EX_MEM(rd_EX_MEM), .regwrite_EX_MEM(regwrite_EX_MEM),
    .rd_MEM_WB(rd_MEM_WB), .regwrite_MEM_WB(regwrite_MEM_WB),
    .branch_taken(branch_taken), .halt_req(halt_req), .step_req(step_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .pipe_flush(pipe_flush),
    .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    return memread_ID_EX && rd_ID_EX != 0 && (rd_ID_EX == rs1_IF_ID || rd_ID_EX == rs2_IF_ID);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (regwrite_EX_MEM && rd_EX_MEM != 0 && rd_EX_MEM == rs) return 2'b10;
    if (regwrite_MEM_WB && rd_MEM_WB != 0 && rd_MEM_WB == rs) return 2'b01;
    return 2'b00;
  endfunction

  // model state advances on the same edge as the DUT
  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_RUN; m_prev = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_mode != M_HALT && !branch_taken && model_lu() && m_stall < MAXC) m_stall++;
      if (branch_taken && m_flush < MAXC) m_flush++;
      if (m_mode == M_RUN) begin
        if (halt_req && !branch_taken) m_mode = M_HALT;
      end else if (m_mode == M_HALT) begin
        if (!halt_req) m_mode = M_RUN;
        else if (step_req && !m_prev) m_mode = M_STEP;
      end else begin
        m_mode = M_HALT;
      end
      m_prev = step_req;
    end
  end

  always @(negedge clk) begin : compare
    logic e_pc, e_ifid, e_fl, e_bub;
    logic [1:0] e_fa, e_fb;
    if (chk_en) begin
      e_fa = model_fwd(rs1_ID_EX);
      e_fb = model_fwd(rs2_ID_EX);
      if (reset) begin
        {e_pc, e_ifid, e_fl, e_bub} = 4'b1100; e_fa = 0; e_fb = 0;
      end else if (m_mode == M_HALT) begin
        {e_pc, e_ifid, e_fl, e_bub} = {2'b00, branch_taken, 1'b1};
      end else if (branch_taken) begin
        {e_pc, e_ifid, e_fl, e_bub} = 4'b1111;
      end else if (model_lu()) begin
        {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
      end else begin
        {e_pc, e_ifid, e_fl, e_bub} = 4'b1100;
      end
      chk("m_pc_en", 32'(pc_en), 32'(e_pc));
      chk("m_if_id_en", 32'(if_id_en), 32'(e_ifid));
      chk("m_pipe_flush", 32'(pipe_flush), 32'(e_fl));
      chk("m_id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
      chk("m_fwd_a", 32'(fwd_a), 32'(e_fa));
      chk("m_fwd_b", 32'(fwd_b), 32'(e_fb));
      chk("m_halted", 32'(halted), 32'(m_mode == M_HALT));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("m_flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    rs1_IF_ID = 0; rs2_IF_ID = 0; rs1_ID_EX = 0; rs2_ID_EX = 0; rd_ID_EX = 0;
    memread_ID_EX = 0; rd_EX_MEM = 0; regwrite_EX_MEM = 0;
    rd_MEM_WB = 0; regwrite_MEM_WB = 0; branch_taken = 0;
  endtask

  task automatic run_count(input int n, input logic s);
    for (int i = 0; i < n; i++) begin
      step_req = s;
      @(negedge clk);
      if (pc_en === 1'b1) cnt++;
      next();
    end
  endtask

  initial begin
    reset = 1; halt_req = 0; step_req = 0;
    clear_pipe();
    // hazards present during reset must not leak through
    memread_ID_EX = 1; rd_ID_EX = 4; rs1_IF_ID = 4;
    regwrite_EX_MEM = 1; rd_EX_MEM = 2; rs1_ID_EX = 2; branch_taken = 1;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_pc_en", 32'(pc_en), 1);
    chk("rst_if_id_en", 32'(if_id_en), 1);
    chk("rst_flush", 32'(pipe_flush), 0);
    chk("rst_bubble", 32'(id_ex_bubble), 0);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    next();
    reset = 0; clear_pipe();
    @(negedge clk);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    next();

    memread_ID_EX = 1; rd_ID_EX = 5; rs1_IF_ID = 5; rs2_IF_ID = 1;
    @(negedge clk);
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_if_id_en", 32'(if_id_en), 0);
    chk("lu_bubble", 32'(id_ex_bubble), 1);
    next();
    clear_pipe(); regwrite_MEM_WB = 1; rd_MEM_WB = 5; rs1_ID_EX = 5;
    @(negedge clk);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    chk("lu_fwd_a_wb", 32'(fwd_a), 2'b01);
    next();

    clear_pipe();
    regwrite_EX_MEM = 1; rd_EX_MEM = 7; regwrite_MEM_WB = 1; rd_MEM_WB = 7; rs1_ID_EX = 7;
    @(negedge clk);
    chk("fwd_mem_prio", 32'(fwd_a), 2'b10);
    next();
    rd_EX_MEM = 0;
    @(negedge clk);
    chk("fwd_wb", 32'(fwd_a), 2'b01);
    next();
    rd_MEM_WB = 0; rs2_ID_EX = 0;
    @(negedge clk);
    chk("fwd_x0", 32'(fwd_b), 2'b00);
    next();

    clear_pipe();
    memread_ID_EX = 1; rd_ID_EX = 9; rs2_IF_ID = 9; branch_taken = 1;
    @(negedge clk);
    chk("br_lu_pc_en", 32'(pc_en), 1);
    chk("br_lu_flush", 32'(pipe_flush), 1);
    chk("br_lu_bubble", 32'(id_ex_bubble), 1);
    next();
    clear_pipe();
    @(negedge clk);
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 1);
    next();

    halt_req = 1;
    next();
    @(negedge clk);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_pc_en", 32'(pc_en), 0);
    next();
    cnt = 0;
    run_count(1, 1); run_count(3, 0); run_count(1, 1); run_count(3, 0);
    chk("step_two_pulses", 32'(cnt), 2);
    cnt = 0;
    run_count(6, 1); run_count(2, 0);
    chk("step_held", 32'(cnt), 1);
    halt_req = 0;
    next();
    @(negedge clk);
    chk("resume_halted", 32'(halted), 0);
    chk("resume_pc_en", 32'(pc_en), 1);
    next();

    halt_req = 1; branch_taken = 1;
    @(negedge clk);
    chk("dh_flush", 32'(pipe_flush), 1);
    next();
    branch_taken = 0;
    @(negedge clk);
    chk("dh_halted_1", 32'(halted), 0);
    next();
    @(negedge clk);
    chk("dh_halted_2", 32'(halted), 1);
    next();
    halt_req = 0;
    next();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      step_req        = ($urandom_range(0, 2) == 0);
      branch_taken    = ($urandom_range(0, 7) == 0);
      memread_ID_EX   = 1'($urandom_range(0, 1));
      regwrite_EX_MEM = 1'($urandom_range(0, 1));
      regwrite_MEM_WB = 1'($urandom_range(0, 1));
      rs1_IF_ID = 5'($urandom_range(0, 3)); rs2_IF_ID = 5'($urandom_range(0, 3));
      rs1_ID_EX = 5'($urandom_range(0, 3)); rs2_ID_EX = 5'($urandom_range(0, 3));
      rd_ID_EX  = 5'($urandom_range(0, 3)); rd_EX_MEM = 5'($urandom_range(0, 3));
      rd_MEM_WB = 5'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      next();
    end

    reset = 0; halt_req = 0; step_req = 0; clear_pipe();
    memread_ID_EX = 1; rd_ID_EX = 3; rs1_IF_ID = 3;
    repeat (MAXC + 5) next();
    @(negedge clk);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    next();
    memread_ID_EX = 0; halt_req = 1;
    next();
    @(negedge clk);
    chk("pre_rst_halted", 32'(halted), 1);
    next();
    reset = 1;
    next();
    reset = 0;
    @(negedge clk);
    chk("post_rst_halted", 32'(halted), 0);
    chk("post_rst_stall", 32'(stall_cnt), 0);
    chk("post_rst_flush", 32'(flush_cnt), 0);
    chk("post_rst_pc_en", 32'(pc_en), 1);
    next();
    halt_req = 0;
    next();
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
